// File: rtl/conv_pkg.sv
// Shared defaults, controller state encoding and partial-sum width helper
// for the convolution PE column.
package conv_pkg;

  localparam int DEF_NUM_PE  = 24;
  localparam int DEF_K       = 3;
  localparam int DEF_IFM_W   = 8;
  localparam int DEF_WGT_W   = 4;
  localparam int DEF_RELU_EN = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // One extra bit per doubling of tap count keeps the K*K accumulation overflow-free.
  function automatic int psum_width(input int ifm_w, input int wgt_w, input int k);
    return ifm_w + wgt_w + $clog2(k * k);
  endfunction

endpackage

// File: rtl/conv_pe_kxk.sv
// One output PE: K*K unsigned-pixel x signed-weight products, a product
// register stage, and the accumulation of the registered products.
module conv_pe_kxk
  import conv_pkg::*;
#(
  parameter int K      = DEF_K,
  parameter int IFM_W  = DEF_IFM_W,
  parameter int WGT_W  = DEF_WGT_W,
  parameter int PSUM_W = psum_width(IFM_W, WGT_W, K)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [K*K*IFM_W-1:0]      pix,
  input  logic [K*K*WGT_W-1:0]      wgt,
  output logic signed [PSUM_W-1:0]  sum
);

  localparam int NTAP = K * K;

  logic signed [PSUM_W-1:0] prod_d [NTAP];
  logic signed [PSUM_W-1:0] prod_q [NTAP];

  always_comb begin
    for (int j = 0; j < NTAP; j++) begin
      prod_d[j] = $signed({{(PSUM_W-IFM_W){1'b0}}, pix[j*IFM_W +: IFM_W]}) *
                  $signed({{(PSUM_W-WGT_W){wgt[j*WGT_W+WGT_W-1]}}, wgt[j*WGT_W +: WGT_W]});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NTAP; j++) prod_q[j] <= '0;
    end else if (en) begin
      for (int j = 0; j < NTAP; j++) prod_q[j] <= prod_d[j];
    end
  end

  always_comb begin
    sum = '0;
    for (int j = 0; j < NTAP; j++) sum = sum + prod_q[j];
  end

endmodule

// File: rtl/conv_pe_column.sv
// Column of NUM_PE KxK convolution PEs sharing a sliding K-column pixel
// window, with weight-load sequencing and a stallable two-stage result pipe.
module conv_pe_column
  import conv_pkg::*;
#(
  parameter int  NUM_PE  = DEF_NUM_PE,
  parameter int  K       = DEF_K,
  parameter int  IFM_W   = DEF_IFM_W,
  parameter int  WGT_W   = DEF_WGT_W,
  parameter int  RELU_EN = DEF_RELU_EN,
  localparam int PSUM_W  = psum_width(IFM_W, WGT_W, K),
  localparam int NPIX    = NUM_PE + K - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wgt_start,
  input  logic                     wgt_valid,
  input  logic [WGT_W-1:0]         wgt_data,
  output logic                     wgt_done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     row_start,
  input  logic [NPIX*IFM_W-1:0]    ifm_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_PE*PSUM_W-1:0] psum_out
);

  // state | meaning
  // IDLE  | no valid weights since reset, columns refused
  // LOAD  | collecting K*K weight beats, columns refused
  // RUN   | weights valid, columns accepted when the pipe can advance

  localparam int NTAP   = K * K;
  localparam int CNT_W  = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int FILL_W = $clog2(K + 1);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         wgt_cnt;
  logic [WGT_W-1:0]         wgt_q [NTAP];
  logic [NTAP*WGT_W-1:0]    wgt_flat;
  logic [NPIX*IFM_W-1:0]    win_q [K];
  logic [FILL_W-1:0]        fill_q, fill_next;
  logic                     advance, accept, last_beat, win_v, s1_v;
  logic [NTAP*IFM_W-1:0]    pe_pix [NUM_PE];
  logic signed [PSUM_W-1:0] pe_sum [NUM_PE];
  logic [NUM_PE*PSUM_W-1:0] psum_d;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = (state_q == RUN) && advance;
  assign accept    = in_valid && in_ready;
  assign wgt_done  = (state_q == RUN);
  assign last_beat = (state_q == LOAD) && wgt_valid && (wgt_cnt == CNT_W'(NTAP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (wgt_start)      state_d = LOAD;
    else if (last_beat) state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wgt_cnt <= '0;
      for (int j = 0; j < NTAP; j++) wgt_q[j] <= '0;
    end else if (wgt_start) begin
      wgt_cnt <= '0;
    end else if ((state_q == LOAD) && wgt_valid) begin
      wgt_q[wgt_cnt] <= wgt_data;
      wgt_cnt        <= wgt_cnt + 1'b1;
    end
  end

  always_comb begin
    if (row_start)                  fill_next = FILL_W'(1);
    else if (fill_q == FILL_W'(K))  fill_next = fill_q;
    else                            fill_next = fill_q + 1'b1;
  end

  // Window column 0 is the oldest; a new column enters at K-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      for (int c = 0; c < K; c++) win_q[c] <= '0;
    end else begin
      if (wgt_start)   fill_q <= '0;
      else if (accept) fill_q <= fill_next;
      if (accept) begin
        for (int c = 0; c < K - 1; c++) win_q[c] <= win_q[c+1];
        win_q[K-1] <= ifm_data;
      end
    end
  end

  always_comb begin
    wgt_flat = '0;
    for (int j = 0; j < NTAP; j++) wgt_flat[j*WGT_W +: WGT_W] = wgt_q[j];
  end

  // Tap r*K+c of PE i sees pixel i+r of window column c; pixel 0 sits at the MSBs.
  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      pe_pix[i] = '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          pe_pix[i][(r*K+c)*IFM_W +: IFM_W] = win_q[c][(NPIX-1-(i+r))*IFM_W +: IFM_W];
    end
  end

  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
    conv_pe_kxk #(
      .K      (K),
      .IFM_W  (IFM_W),
      .WGT_W  (WGT_W),
      .PSUM_W (PSUM_W)
    ) u_pe (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (advance),
      .pix   (pe_pix[gi]),
      .wgt   (wgt_flat),
      .sum   (pe_sum[gi])
    );
  end

  always_comb begin
    psum_d = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if ((RELU_EN != 0) && pe_sum[i][PSUM_W-1])
        psum_d[(NUM_PE-1-i)*PSUM_W +: PSUM_W] = '0;
      else
        psum_d[(NUM_PE-1-i)*PSUM_W +: PSUM_W] = pe_sum[i];
    end
  end

  // win_v marks a complete window captured this beat; it rides alongside the PE product stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_v     <= 1'b0;
      s1_v      <= 1'b0;
      out_valid <= 1'b0;
      psum_out  <= '0;
    end else if (wgt_start) begin
      win_v     <= 1'b0;
      s1_v      <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      win_v     <= accept && (fill_next == FILL_W'(K));
      s1_v      <= win_v;
      out_valid <= s1_v;
      if (s1_v) psum_out <= psum_d;
    end
  end

endmodule

// File: tb/tb_conv_pe_column.sv
// Directed bench for conv_pe_column (NUM_PE=4, K=3), one plain and one ReLU instance.
module tb_conv_pe_column;

  logic        clk = 1'b0;
  logic        rst_n, wgt_start, wgt_valid, in_valid, row_start, out_ready;
  logic [3:0]  wgt_data;
  logic [47:0] ifm_data;
  logic        wgt_done, in_ready, out_valid;
  logic [63:0] psum_out;
  logic        r_wgt_done, r_in_ready, r_out_valid;
  logic [63:0] r_psum_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conv_pe_column #(.NUM_PE(4), .K(3), .IFM_W(8), .WGT_W(4), .RELU_EN(0)) dut (
    .clk(clk), .rst_n(rst_n), .wgt_start(wgt_start), .wgt_valid(wgt_valid),
    .wgt_data(wgt_data), .wgt_done(wgt_done), .in_valid(in_valid), .in_ready(in_ready),
    .row_start(row_start), .ifm_data(ifm_data), .out_valid(out_valid),
    .out_ready(out_ready), .psum_out(psum_out));

  conv_pe_column #(.NUM_PE(4), .K(3), .IFM_W(8), .WGT_W(4), .RELU_EN(1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .wgt_start(wgt_start), .wgt_valid(wgt_valid),
    .wgt_data(wgt_data), .wgt_done(r_wgt_done), .in_valid(in_valid), .in_ready(r_in_ready),
    .row_start(row_start), .ifm_data(ifm_data), .out_valid(r_out_valid),
    .out_ready(out_ready), .psum_out(r_psum_out));

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [47:0] col_u(input logic [7:0] v);
    return {6{v}};
  endfunction

  // ws holds W[0][0] at the MSBs
  task automatic load_wgts(input logic [35:0] ws);
    wgt_start = 1'b1;
    tick();
    wgt_start = 1'b0;
    wgt_valid = 1'b1;
    for (int j = 0; j < 9; j++) begin
      wgt_data = ws[(8-j)*4 +: 4];
      tick();
    end
    wgt_valid = 1'b0;
  endtask

  task automatic send_col(input logic [47:0] d, input logic rs);
    in_valid  = 1'b1;
    ifm_data  = d;
    row_start = rs;
    tick();
    in_valid  = 1'b0;
    row_start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wgt_start = 0; wgt_valid = 0; wgt_data = 0;
    in_valid = 0; row_start = 0; out_ready = 1; ifm_data = '0;
    repeat (2) tick();
    checks++; if ({in_ready, out_valid, wgt_done} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {in_ready, out_valid, wgt_done}); end
    checks++; if (psum_out !== 64'h0) begin
      errors++; $display("FAIL reset_psum: got %h expected 0", psum_out); end
    rst_n = 1'b1;
    in_valid = 1'b1; ifm_data = col_u(8'd9);
    tick();
    checks++; if (in_ready !== 1'b0) begin
      errors++; $display("FAIL idle_in_ready: got %b expected 0", in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_basic;
    wgt_start = 1'b1;
    tick();
    wgt_start = 1'b0;
    checks++; if (wgt_done !== 1'b0) begin
      errors++; $display("FAIL load_wgt_done: got %b expected 0", wgt_done); end
    wgt_valid = 1'b1; wgt_data = 4'h1;
    for (int j = 0; j < 9; j++) begin
      checks++; if (in_ready !== 1'b0) begin
        errors++; $display("FAIL load_in_ready beat %0d: got %b expected 0", j, in_ready); end
      tick();
    end
    wgt_valid = 1'b0;
    checks++; if ({wgt_done, in_ready} !== 2'b11) begin
      errors++; $display("FAIL run_entry: got %b expected 11", {wgt_done, in_ready}); end
    for (int k = 0; k < 3; k++) begin
      send_col(col_u(8'd2), k == 0);
      checks++; if (out_valid !== 1'b0) begin
        errors++; $display("FAIL early_valid col %0d: got %b expected 0", k, out_valid); end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin
      errors++; $display("FAIL latency_1: got %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin
      errors++; $display("FAIL latency_2: got %b expected 1", out_valid); end
    checks++; if (psum_out !== {4{16'd18}}) begin
      errors++; $display("FAIL basic_psum: got %h expected %h", psum_out, {4{16'd18}}); end
    checks++; if (r_psum_out !== {4{16'd18}}) begin
      errors++; $display("FAIL basic_psum_relu: got %h expected %h", r_psum_out, {4{16'd18}}); end
    tick();
    checks++; if (out_valid !== 1'b0) begin
      errors++; $display("FAIL valid_drop: got %b expected 0", out_valid); end
  endtask

  task automatic test_neg_relu;
    load_wgts({9{4'hF}});
    for (int k = 0; k < 3; k++) send_col(col_u(8'd255), k == 0);
    repeat (2) tick();
    checks++; if ({out_valid, r_out_valid} !== 2'b11) begin
      errors++; $display("FAIL neg_valid: got %b expected 11", {out_valid, r_out_valid}); end
    checks++; if (psum_out !== {4{16'hF709}}) begin
      errors++; $display("FAIL neg_psum: got %h expected %h", psum_out, {4{16'hF709}}); end
    checks++; if (r_psum_out !== 64'h0) begin
      errors++; $display("FAIL relu_psum: got %h expected 0", r_psum_out); end
    tick();
  endtask

  // W[0][0]=1, W[2][2]=-1: PE i = oldest[i] - newest[i+2]
  task automatic test_pattern;
    load_wgts({4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF});
    wgt_valid = 1'b1; wgt_data = 4'h7;
    send_col({8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60}, 1'b1);
    send_col(48'h0, 1'b0);
    send_col({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, 1'b0);
    wgt_valid = 1'b0;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b1) begin
      errors++; $display("FAIL pattern_valid: got %b expected 1", out_valid); end
    checks++; if (psum_out !== {16'd7, 16'd16, 16'd25, 16'd34}) begin
      errors++; $display("FAIL pattern_psum: got %h expected %h", psum_out, {16'd7, 16'd16, 16'd25, 16'd34}); end
    tick();
  endtask

  task automatic test_stall;
    logic [15:0] exp_s [3];
    int got;
    exp_s = '{16'd18, 16'd27, 16'd36};
    load_wgts({9{4'h1}});
    for (int k = 1; k <= 4; k++) send_col(col_u(8'(k)), k == 1);
    out_ready = 1'b0;
    send_col(col_u(8'd5), 1'b0);
    for (int n = 0; n < 5; n++) begin
      checks++; if (in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_in_ready cyc %0d: got %b expected 0", n, in_ready); end
      checks++; if (out_valid !== 1'b1 || psum_out !== {4{16'd18}}) begin
        errors++; $display("FAIL stall_hold cyc %0d: got %b/%h expected 1/%h", n, out_valid, psum_out, {4{16'd18}}); end
      tick();
    end
    out_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid) begin
        checks++; if (got >= 3 || psum_out !== {4{exp_s[got % 3]}}) begin
          errors++; $display("FAIL stall_order idx %0d: got %h expected %h", got, psum_out, {4{exp_s[got % 3]}}); end
        got++;
      end
      tick();
    end
    checks++; if (got != 3) begin
      errors++; $display("FAIL stall_count: got %0d expected 3", got); end
  endtask

  task automatic test_row_start;
    logic [63:0] q[$];
    logic [15:0] exp_r [3];
    exp_r = '{16'd18, 16'd27, 16'd54};
    load_wgts({9{4'h1}});
    for (int k = 1; k <= 7; k++) begin
      send_col(col_u(8'(k)), (k == 1) || (k == 5));
      if (out_valid) q.push_back(psum_out);
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      if (out_valid) q.push_back(psum_out);
    end
    checks++; if (q.size() != 3) begin
      errors++; $display("FAIL row_count: got %0d expected 3", q.size()); end
    for (int j = 0; j < 3 && j < q.size(); j++) begin
      checks++; if (q[j] !== {4{exp_r[j]}}) begin
        errors++; $display("FAIL row_psum idx %0d: got %h expected %h", j, q[j], {4{exp_r[j]}}); end
    end
  endtask

  task automatic test_reload;
    int cnt;
    load_wgts({9{4'h1}});
    for (int k = 1; k <= 4; k++) send_col(col_u(8'(k)), k == 1);
    wgt_start = 1'b1;
    tick();
    wgt_start = 1'b0;
    checks++; if ({wgt_done, in_ready, out_valid} !== 3'b000) begin
      errors++; $display("FAIL reload_entry: got %b expected 000", {wgt_done, in_ready, out_valid}); end
    wgt_valid = 1'b1; wgt_data = 4'h2;
    for (int j = 0; j < 9; j++) begin
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL reload_beat %0d: got ready=%b valid=%b expected 0/0", j, in_ready, out_valid); end
      tick();
    end
    wgt_valid = 1'b0;
    checks++; if ({wgt_done, in_ready} !== 2'b11) begin
      errors++; $display("FAIL reload_done: got %b expected 11", {wgt_done, in_ready}); end
    for (int k = 0; k < 3; k++) send_col(col_u(8'd3), k == 0);
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      if (out_valid) begin
        cnt++;
        checks++; if (psum_out !== {4{16'd54}}) begin
          errors++; $display("FAIL reload_psum: got %h expected %h", psum_out, {4{16'd54}}); end
      end
      tick();
    end
    checks++; if (cnt != 1) begin
      errors++; $display("FAIL reload_count: got %0d expected 1", cnt); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) send_col(col_u(8'(k)), k == 1);
    repeat (2) tick();
    checks++; if (out_valid !== 1'b1 || psum_out !== {4{16'd36}}) begin
      errors++; $display("FAIL pre_reset: got %b/%h expected 1/%h", out_valid, psum_out, {4{16'd36}}); end
    in_valid = 1'b1; ifm_data = col_u(8'd9);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({wgt_done, in_ready, out_valid, r_out_valid} !== 4'b0000) begin
      errors++; $display("FAIL async_flags: got %b expected 0000", {wgt_done, in_ready, out_valid, r_out_valid}); end
    checks++; if (psum_out !== 64'h0 || r_psum_out !== 64'h0) begin
      errors++; $display("FAIL async_psum: got %h/%h expected 0/0", psum_out, r_psum_out); end
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL post_reset cyc %0d: got ready=%b valid=%b expected 0/0", n, in_ready, out_valid); end
    end
    in_valid = 1'b0;
    load_wgts({9{4'h1}});
    checks++; if (in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reload_ready: got %b expected 1", in_ready); end
    for (int k = 0; k < 3; k++) send_col(col_u(8'd5), k == 0);
    repeat (2) tick();
    checks++; if (out_valid !== 1'b1 || psum_out !== {4{16'd45}}) begin
      errors++; $display("FAIL post_reset_psum: got %b/%h expected 1/%h", out_valid, psum_out, {4{16'd45}}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg_relu();
    test_pattern();
    test_stall();
    test_row_start();
    test_reload();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_pe_column.md
CONV_PE_COLUMN -- requirements
Module: conv_pe_column

Interface
REQ-001 SHALL have parameter NUM_PE, default 24, meaning the number of output PEs (output rows) per column.
REQ-002 SHALL have parameter K, default 3, meaning the square kernel size.
REQ-003 SHALL have parameter IFM_W, default 8, meaning the unsigned pixel width.
REQ-004 SHALL have parameter WGT_W, default 4, meaning the signed two's-complement weight width.
REQ-005 SHALL have parameter RELU_EN, default 0, meaning that when 1, negative results are clamped to 0.
REQ-006 SHALL derive localparam PSUM_W = IFM_W+WGT_W+clog2(K*K) and localparam NPIX = NUM_PE+K-1.
REQ-007 SHALL have port: clk, input, 1, the single clock.
REQ-008 SHALL have port: rst_n, input, 1, reset that is asynchronous and active-low.
REQ-009 SHALL have port: wgt_start, input, 1, a pulse that begins a weight load.
REQ-010 SHALL have port: wgt_valid, input, 1, a weight beat qualifier.
REQ-011 SHALL have port: wgt_data, input, WGT_W, one weight per beat in row-major order W[0][0]..W[K-1][K-1].
REQ-012 SHALL have port: wgt_done, output, 1, high while valid weights are held.
REQ-013 SHALL have port: in_valid, input, 1, an ifmap column beat qualifier.
REQ-014 SHALL have port: in_ready, output, 1, column accept.
REQ-015 SHALL have port: row_start, input, 1, marking that the beat is the first column of a new row band.
REQ-016 SHALL have port: ifm_data, input, NPIX*IFM_W, with pixel 0 (top) at the MSBs.
REQ-017 SHALL have port: out_valid, output, 1, result valid.
REQ-018 SHALL have port: out_ready, input, 1, result accept.
REQ-019 SHALL have port: psum_out, output, NUM_PE*PSUM_W, with PE 0 at the MSBs.

Function
REQ-020 SHALL implement the FSM states IDLE, LOAD and RUN.
REQ-021 SHALL move from IDLE or RUN to LOAD on wgt_start, clear the weight counter, clear the window fill count and invalidate all pipeline stages.
REQ-022 SHALL, in LOAD, store wgt_data into weight slot cnt on each wgt_valid beat; after beat K*K-1, go to RUN and set wgt_done=1.
REQ-023 SHALL hold wgt_done=0 from wgt_start until the load completes.
REQ-024 SHALL ignore wgt_valid outside LOAD.
REQ-025 SHALL restart the count at 0 on a wgt_start that occurs in LOAD.
REQ-026 SHALL define advance = !out_valid || out_ready.
REQ-027 SHALL drive in_ready = (state==RUN) && advance.
REQ-028 SHALL drive in_ready=0 in IDLE and LOAD.
REQ-029 SHALL treat a beat as accepted when in_valid && in_ready; on accept, the K-column window shifts in ifm_data as its newest column.
REQ-030 SHALL update the fill count, saturating at K, as follows: row_start on an accepted beat sets fill=1, otherwise fill=min(fill+1,K).
REQ-031 SHALL define the result for PE i at an accepted beat with post-update fill==K as the sum over r,c in 0..K-1 of W[r][c]*X[i+r][oldest+c], where column c=0 is the oldest.
REQ-032 SHALL produce no result for a beat whose post-update fill is less than K.
REQ-033 SHALL use a two-stage pipeline: stage 1 registers the products and partial sums at the edge after accept; stage 2 registers psum_out and out_valid on the following edge.
REQ-034 SHALL give out_valid a latency of exactly 2 cycles after the accepting edge when unstalled.
REQ-035 SHALL freeze the window, both stages, out_valid and psum_out when advance=0.
REQ-036 SHALL hold psum_out stable while out_valid && !out_ready.
REQ-037 SHALL sustain a throughput of 1 result per cycle with out_ready held at 1.
REQ-038 SHALL compute with pixels zero-extended, weights sign-extended, and products and sums signed PSUM_W with no overflow possible.
REQ-039 SHALL, when RELU_EN=1, output negative sums as 0.
REQ-040 SHALL clear out_valid when out_ready is high and no new result is entering stage 2.

Reset
REQ-041 SHALL, on rst_n low, asynchronously force state=IDLE, wgt_done=0, in_ready=0, out_valid=0, psum_out=0, fill=0, all weights=0, all window pixels=0 and all stage-1 registers and valids=0.
REQ-042 SHALL, on reset mid-operation, discard all in-flight results and require a full weight reload before accepting columns.

Structure
REQ-043 SHALL place the default parameters, the FSM state encoding and the PSUM_W width function in shared package conv_pkg.
REQ-044 SHALL use one sub-module, conv_pe_kxk, holding a single PE's K*K multiply array, stage-1 register and adder tree, instantiated NUM_PE times via generate.

Verification
REQ-045 SHALL check: with NUM_PE=4 and K=3, load all weights +1 and stream three columns of pixel value 2 -> every psum equals 18, out_valid rises 2 cycles after the third accept, and no out_valid is seen before that.
REQ-046 SHALL check: with weights all 4'hF (-1), pixels 255 and RELU_EN=0 -> psum equals -2295; with RELU_EN=1 -> psum equals 0.
REQ-047 SHALL check: holding out_ready=0 for 5 cycles while results are pending -> in_ready=0 throughout, psum_out is unchanged, and all results arrive in order after release.
REQ-048 SHALL check: row_start on the 5th column of a stream -> no result for columns 5 and 6, and the next result appears on column 7, computed only from columns 5-7.
REQ-049 SHALL check: wgt_start during RUN with 2 results in flight -> both are discarded, in_ready=0 until 9 weight beats complete, and the new weights apply to subsequent results.
REQ-050 SHALL check: rst_n asserted mid-stream -> all outputs are 0 immediately (asynchronously), and in_ready stays 0 after release until a weight load completes.
